// File: rtl/pp_pipeline_accel_pkg.sv
// Shared types and helpers for the pp_pipeline_accel region.
// Holds the writer FSM states and the AXI burst-length rule.
package pp_pipeline_accel_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PARAM,
    S_AW,
    S_W,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int AXI_LEN_W  = 8;
  localparam int PAGE_BYTES = 4096;

  // beats = min(remaining, max_burst, beats left in the 4 KB page)
  function automatic logic [15:0] calc_beats(
    input logic [15:0] remaining,
    input logic [15:0] max_burst,
    input logic [11:0] addr_lo,
    input int          shift
  );
    logic [12:0] room;
    logic [15:0] b;
    room = (13'(PAGE_BYTES) - {1'b0, addr_lo}) >> shift;
    b = remaining;
    if (max_burst < b) b = max_burst;
    if ({3'b000, room} < b) b = {3'b000, room};
    return b;
  endfunction

endpackage

// File: rtl/pp_pipeline_accel_mem_writer_if.sv
// AXI4-style write-master channel bundle for the memory writer.
// The writer drives the master side; memory drives the slave side.
interface pp_pipeline_accel_mem_writer_if
  import pp_pipeline_accel_pkg::*;
#(
  parameter int DATA_W = 64
);
  logic                 awvalid;
  logic                 awready;
  logic [63:0]          awaddr;
  logic [AXI_LEN_W-1:0] awlen;
  logic                 wvalid;
  logic                 wready;
  logic [DATA_W-1:0]    wdata;
  logic                 wlast;
  logic                 bvalid;
  logic                 bready;

  modport master (
    output awvalid, awaddr, awlen,
    output wvalid, wdata, wlast,
    output bready,
    input  awready, wready, bvalid
  );

  modport slave (
    input  awvalid, awaddr, awlen,
    input  wvalid, wdata, wlast,
    input  bready,
    output awready, wready, bvalid
  );
endinterface

// File: rtl/pp_pipeline_accel_burst_calc.sv
// Combinational burst sizer: splits at row end, MAX_BURST and 4 KB.
// Produces the beat count and the matching AXI length field.
module pp_pipeline_accel_burst_calc
  import pp_pipeline_accel_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 16
) (
  input  logic [15:0]          remaining_i,
  input  logic [11:0]          addr_lo_i,
  output logic [15:0]          beats_o,
  output logic [AXI_LEN_W-1:0] awlen_o
);
  localparam int SHIFT = $clog2(DATA_W / 8);

  assign beats_o = calc_beats(remaining_i, 16'(MAX_BURST),
                              addr_lo_i, SHIFT);
  assign awlen_o = AXI_LEN_W'(beats_o - 16'd1);
endmodule

// File: rtl/pp_pipeline_accel_mem_writer.sv
// Dataflow sink: pops base/rows parameters, streams pixels to memory
// through an AXI4-style write master with bounded outstanding bursts.
module pp_pipeline_accel_mem_writer
  import pp_pipeline_accel_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 16,
  parameter int MAX_OUT   = 4
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  input  logic              ap_continue,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [15:0]       cols,
  input  logic [63:0]       dout_c_dout,
  input  logic              dout_c_empty_n,
  output logic              dout_c_read,
  input  logic [15:0]       rows_c_dout,
  input  logic              rows_c_empty_n,
  output logic              rows_c_read,
  input  logic [DATA_W-1:0] pix_dout,
  input  logic              pix_empty_n,
  output logic              pix_read,
  pp_pipeline_accel_mem_writer_if.master m
);
  localparam int BPB = DATA_W / 8;
  localparam int OW  = $clog2(MAX_OUT + 1);

  state_e state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [15:0] rows_q, rows_d;
  logic [15:0] cols_q, cols_d;
  logic [15:0] row_q, row_d;
  logic [15:0] col_q, col_d;
  logic [15:0] beats_q, beats_d;
  logic [15:0] beat_q, beat_d;
  logic [OW-1:0] out_q, out_d;

  logic [15:0]          rem;
  logic [15:0]          cb_beats;
  logic [AXI_LEN_W-1:0] cb_len;
  logic aw_hs, b_hs, last_col, last_img;

  assign rem = cols_q - col_q;

  pp_pipeline_accel_burst_calc #(
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) u_calc (
    .remaining_i (rem),
    .addr_lo_i   (addr_q[11:0]),
    .beats_o     (cb_beats),
    .awlen_o     (cb_len)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rows_d   = rows_q;
    cols_d   = cols_q;
    row_d    = row_q;
    col_d    = col_q;
    beats_d  = beats_q;
    beat_d   = beat_q;
    aw_hs    = 1'b0;
    last_col = col_q == cols_q - 16'd1;
    last_img = last_col && (row_q == rows_q - 16'd1);
    ap_done     = 1'b0;
    ap_idle     = 1'b0;
    ap_ready    = 1'b0;
    dout_c_read = 1'b0;
    rows_c_read = 1'b0;
    pix_read    = 1'b0;
    m.awvalid = 1'b0;
    m.awaddr  = addr_q;
    m.awlen   = cb_len;
    m.wvalid  = 1'b0;
    m.wdata   = pix_dout;
    m.wlast   = 1'b0;
    m.bready  = !ap_rst;
    unique case (state_q)
      S_IDLE: begin
        ap_idle = !ap_start;
        if (ap_start) state_d = S_PARAM;
      end
      S_PARAM: begin
        if (dout_c_empty_n && rows_c_empty_n) begin
          dout_c_read = 1'b1;
          rows_c_read = 1'b1;
          ap_ready    = 1'b1;
          addr_d = dout_c_dout;
          rows_d = rows_c_dout;
          cols_d = cols;
          row_d  = '0;
          col_d  = '0;
          if (rows_c_dout == '0 || cols == '0)
            state_d = S_DONE;
          else
            state_d = S_AW;
        end
      end
      S_AW: begin
        m.awvalid = out_q < OW'(MAX_OUT);
        if (m.awvalid && m.awready) begin
          aw_hs   = 1'b1;
          beats_d = cb_beats;
          beat_d  = '0;
          state_d = S_W;
        end
      end
      S_W: begin
        m.wvalid = pix_empty_n;
        m.wlast  = beat_q == beats_q - 16'd1;
        if (m.wvalid && m.wready) begin
          pix_read = 1'b1;
          addr_d   = addr_q + 64'(BPB);
          beat_d   = beat_q + 16'd1;
          if (last_col) begin
            col_d = '0;
            row_d = row_q + 16'd1;
          end else begin
            col_d = col_q + 16'd1;
          end
          if (m.wlast) state_d = last_img ? S_DRAIN : S_AW;
        end
      end
      S_DRAIN: begin
        if (out_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        ap_done = 1'b1;
        if (ap_continue) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    b_hs  = m.bvalid && !ap_rst && (out_q != '0);
    out_d = out_q + OW'(aw_hs) - OW'(b_hs);
    // strobes stay quiet while reset is held, whatever the state
    if (ap_rst) begin
      ap_done     = 1'b0;
      ap_ready    = 1'b0;
      dout_c_read = 1'b0;
      rows_c_read = 1'b0;
      pix_read    = 1'b0;
      m.awvalid   = 1'b0;
      m.wvalid    = 1'b0;
      m.wlast     = 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      beats_q <= '0;
      beat_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      row_q   <= row_d;
      col_q   <= col_d;
      beats_q <= beats_d;
      beat_q  <= beat_d;
      out_q   <= out_d;
    end
  end
endmodule

// File: tb/tb_pp_pipeline_accel_mem_writer.sv
// Randomized bench for the memory writer with a burst-list reference
// model, FIFO/AXI slave models and per-scenario checking tasks.
module tb_pp_pipeline_accel_mem_writer;
  import pp_pipeline_accel_pkg::*;

  localparam int DW = 64;
  localparam int MB = 16;
  localparam int MO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          ap_rst, ap_start, ap_done, ap_continue;
  logic          ap_idle, ap_ready;
  logic [15:0]   cols;
  logic [63:0]   dout_c_dout;
  logic          dout_c_empty_n, dout_c_read;
  logic [15:0]   rows_c_dout;
  logic          rows_c_empty_n, rows_c_read;
  logic [DW-1:0] pix_dout;
  logic          pix_empty_n, pix_read;

  pp_pipeline_accel_mem_writer_if #(.DATA_W(DW)) mif ();

  pp_pipeline_accel_mem_writer #(
    .DATA_W(DW), .MAX_BURST(MB), .MAX_OUT(MO)
  ) dut (
    .ap_clk         (clk),
    .ap_rst         (ap_rst),
    .ap_start       (ap_start),
    .ap_done        (ap_done),
    .ap_continue    (ap_continue),
    .ap_idle        (ap_idle),
    .ap_ready       (ap_ready),
    .cols           (cols),
    .dout_c_dout    (dout_c_dout),
    .dout_c_empty_n (dout_c_empty_n),
    .dout_c_read    (dout_c_read),
    .rows_c_dout    (rows_c_dout),
    .rows_c_empty_n (rows_c_empty_n),
    .rows_c_read    (rows_c_read),
    .pix_dout       (pix_dout),
    .pix_empty_n    (pix_empty_n),
    .pix_read       (pix_read),
    .m              (mif)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] pixq[$];
  logic [63:0]   par_addr[$];
  logic [15:0]   par_rows[$];
  logic [63:0]   aw_addr[$];
  logic [7:0]    aw_len[$];
  logic [DW-1:0] w_data[$];
  logic          w_last[$];
  logic [63:0]   ex_addr[$];
  logic [7:0]    ex_len[$];
  logic [DW-1:0] ex_data[$];
  logic          ex_last[$];

  int pend_b = 0, over_cnt = 0, pair_bad = 0, pr_bad = 0;
  int rd_cyc = 0, rdy_cyc = 0, done_cyc = 0;
  bit pop_pix = 0, pop_par = 0, rnd_rdy = 0, b_en = 1;

  // FIFO and memory-slave models, updated just after each edge
  always @(posedge clk) begin
    #1;
    if (ap_rst) begin
      pixq.delete();
      par_addr.delete();
      par_rows.delete();
    end else begin
      if (pop_pix && pixq.size() > 0) void'(pixq.pop_front());
      if (pop_par && par_addr.size() > 0) begin
        void'(par_addr.pop_front());
        void'(par_rows.pop_front());
      end
    end
    pix_empty_n = pixq.size() > 0 &&
                  (!rnd_rdy || $urandom_range(3) != 0);
    pix_dout = pixq.size() > 0 ? pixq[0] : '0;
    dout_c_empty_n = par_addr.size() > 0;
    rows_c_empty_n = par_rows.size() > 0;
    dout_c_dout = par_addr.size() > 0 ? par_addr[0] : '0;
    rows_c_dout = par_rows.size() > 0 ? par_rows[0] : '0;
    mif.awready = !rnd_rdy || $urandom_range(1) == 1;
    mif.wready  = !rnd_rdy || $urandom_range(1) == 1;
    mif.bvalid  = b_en && pend_b > 0 &&
                  (!rnd_rdy || $urandom_range(1) == 1);
  end

  // handshake monitor
  always @(negedge clk) begin
    pop_pix = pix_read;
    pop_par = dout_c_read;
    if (ap_rst) begin
      pend_b = 0; over_cnt = 0; pair_bad = 0; pr_bad = 0;
      rd_cyc = 0; rdy_cyc = 0; done_cyc = 0;
      aw_addr.delete(); aw_len.delete();
      w_data.delete(); w_last.delete();
    end else begin
      if (dout_c_read !== rows_c_read) pair_bad++;
      if (pix_read !== (mif.wvalid && mif.wready)) pr_bad++;
      if (dout_c_read) rd_cyc++;
      if (ap_ready) rdy_cyc++;
      if (ap_done) done_cyc++;
      if (mif.awvalid && pend_b >= MO) over_cnt++;
      if (mif.awvalid && mif.awready) begin
        aw_addr.push_back(mif.awaddr);
        aw_len.push_back(mif.awlen);
        pend_b++;
      end
      if (mif.bvalid && mif.bready) pend_b--;
      if (mif.wvalid && mif.wready) begin
        w_data.push_back(mif.wdata);
        w_last.push_back(mif.wlast);
      end
    end
  end

  // reference: walk the image row by row and cut bursts by the rules
  function automatic void build_model(input logic [63:0] base,
                                      input int r, input int c);
    longint a, rem, room, b;
    ex_addr.delete(); ex_len.delete(); ex_last.delete();
    a = longint'(base);
    for (int rr = 0; rr < r; rr++) begin
      rem = c;
      while (rem > 0) begin
        room = (4096 - (a % 4096)) / (DW / 8);
        b = rem;
        if (b > MB) b = MB;
        if (b > room) b = room;
        ex_addr.push_back(64'(a));
        ex_len.push_back(8'(b - 1));
        for (longint k = 0; k < b; k++) ex_last.push_back(k == b - 1);
        a += b * (DW / 8);
        rem -= b;
      end
    end
  endfunction

  function automatic int aw_err();
    int e = 0;
    if (aw_addr.size() != ex_addr.size()) return 999;
    foreach (aw_addr[i])
      if (aw_addr[i] !== ex_addr[i] || aw_len[i] !== ex_len[i]) e++;
    return e;
  endfunction

  function automatic int w_err();
    int e = 0;
    if (w_data.size() != ex_data.size()) return 999;
    foreach (w_data[i])
      if (w_data[i] !== ex_data[i] || w_last[i] !== ex_last[i]) e++;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    ap_rst = 1'b1; ap_start = 1'b0; ap_continue = 1'b0;
    b_en = 1'b1; rnd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 ap_rst = 1'b0;
  endtask

  task automatic start_image(input logic [63:0] base,
                             input int r, input int c);
    logic [DW-1:0] d;
    @(negedge clk);
    build_model(base, r, c);
    ex_data.delete();
    for (int i = 0; i < r * c; i++) begin
      d = {$urandom, $urandom};
      pixq.push_back(d);
      ex_data.push_back(d);
    end
    par_addr.push_back(base);
    par_rows.push_back(16'(r));
    cols = 16'(c);
    ap_start = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if (ap_ready) ap_start = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ap_ready) ap_start = 1'b0;
      if (ap_done) begin ok = 1; break; end
    end
  endtask

  task automatic finish_run();
    ap_continue = 1'b1;
    @(negedge clk);
    ap_continue = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    @(negedge clk);
    ap_rst = 1'b1; ap_start = 1'b0; ap_continue = 1'b0;
    repeat (2) @(negedge clk);
    v = {ap_done, ap_ready, dout_c_read, rows_c_read, pix_read,
         mif.awvalid, mif.wvalid, mif.wlast};
    total++;
    if (v !== 8'h00) begin
      bad++; $display("FAIL rst_strobes got=%b want=00000000", v);
    end
    total++;
    if (mif.bready !== 1'b0) begin
      bad++; $display("FAIL rst_bready got=%b want=0", mif.bready);
    end
    @(posedge clk); #1 ap_rst = 1'b0;
    @(negedge clk);
    total++;
    if (mif.bready !== 1'b1 || ap_idle !== 1'b1) begin
      bad++;
      $display("FAIL rst_release bready=%b idle=%b want=1 1",
               mif.bready, ap_idle);
    end
  endtask

  task automatic test_burst_split();
    logic [63:0] bases[3] = '{64'h1000, 64'h0, 64'h0FF0};
    int rs[3]  = '{2, 1, 1};
    int cs[3]  = '{8, 40, 8};
    int nb[3]  = '{2, 3, 2};
    int fl[3]  = '{7, 15, 1};
    bit ok;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      start_image(bases[k], rs[k], cs[k]);
      wait_done(3000, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL split%0d timeout", k); end
      total++;
      if (aw_addr.size() != nb[k] || aw_len.size() == 0 ||
          aw_len[0] != 8'(fl[k])) begin
        bad++;
        $display("FAIL split%0d nburst got=%0d want=%0d", k,
                 aw_addr.size(), nb[k]);
      end
      total++;
      if (aw_err() != 0) begin
        bad++; $display("FAIL split%0d aw errs=%0d want=0", k, aw_err());
      end
      total++;
      if (w_err() != 0) begin
        bad++; $display("FAIL split%0d w errs=%0d want=0", k, w_err());
      end
      finish_run();
      @(negedge clk);
      total++;
      if (ap_done !== 1'b0 || ap_idle !== 1'b1) begin
        bad++;
        $display("FAIL split%0d idle done=%b idle=%b want=0 1",
                 k, ap_done, ap_idle);
      end
    end
  endtask

  task automatic test_outstanding();
    bit ok;
    do_reset();
    b_en = 1'b0;
    start_image(64'h2000, 6, 4);
    cycles(80);
    total++;
    if (aw_addr.size() != MO || mif.awvalid !== 1'b0) begin
      bad++;
      $display("FAIL outst_cap aw=%0d awvalid=%b want=%0d 0",
               aw_addr.size(), mif.awvalid, MO);
    end
    b_en = 1'b1;
    wait_done(3000, ok);
    total++;
    if (!ok || over_cnt != 0) begin
      bad++; $display("FAIL outst_run done=%0d over=%0d want=1 0",
                      ok, over_cnt);
    end
    total++;
    if (aw_err() != 0 || w_err() != 0) begin
      bad++; $display("FAIL outst_data aw=%0d w=%0d want=0 0",
                      aw_err(), w_err());
    end
    finish_run();
  endtask

  task automatic test_zero_dims();
    int rs[2] = '{0, 3};
    int cs[2] = '{5, 0};
    int held;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      start_image(64'h3000, rs[k], cs[k]);
      wait_done(200, ok);
      held = 0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (ap_done) held++;
      end
      total++;
      if (!ok || held != 3) begin
        bad++; $display("FAIL zero%0d done_hold got=%0d want=3", k, held);
      end
      total++;
      if (rd_cyc != 1 || rdy_cyc != 1 || pair_bad != 0) begin
        bad++; $display("FAIL zero%0d reads=%0d ready=%0d want=1 1",
                        k, rd_cyc, rdy_cyc);
      end
      total++;
      if (aw_addr.size() != 0 || w_data.size() != 0) begin
        bad++; $display("FAIL zero%0d traffic aw=%0d w=%0d want=0 0",
                        k, aw_addr.size(), w_data.size());
      end
      finish_run();
      @(negedge clk);
      total++;
      if (ap_done !== 1'b0 || ap_idle !== 1'b1) begin
        bad++; $display("FAIL zero%0d idle done=%b idle=%b want=0 1",
                        k, ap_done, ap_idle);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] base;
    int r, c;
    bit ok;
    for (int k = 0; k < 6; k++) begin
      do_reset();
      rnd_rdy = 1'b1;
      ap_continue = 1'b1;
      base = 64'($urandom_range(0, 32'h3FFFF)) << 3;
      r = $urandom_range(1, 4);
      c = $urandom_range(1, 40);
      start_image(base, r, c);
      wait_done(4000, ok);
      repeat (2) @(negedge clk);
      total++;
      if (!ok || done_cyc != 1) begin
        bad++; $display("FAIL rand%0d done_pulse got=%0d want=1",
                        k, done_cyc);
      end
      total++;
      if (aw_err() != 0 || w_err() != 0) begin
        bad++; $display("FAIL rand%0d data aw=%0d w=%0d want=0 0",
                        k, aw_err(), w_err());
      end
      total++;
      if (over_cnt != 0 || pr_bad != 0 || pair_bad != 0) begin
        bad++; $display("FAIL rand%0d proto over=%0d pr=%0d pair=%0d",
                        k, over_cnt, pr_bad, pair_bad);
      end
      ap_continue = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    start_image(64'h4000, 4, 16);
    for (int i = 0; i < 500 && w_data.size() < 5; i++) cycles(1);
    @(posedge clk); #1 ap_rst = 1'b1;
    @(posedge clk); #1 ap_rst = 1'b0;
    @(negedge clk);
    total++;
    if (mif.awvalid !== 1'b0 || mif.wvalid !== 1'b0 ||
        pix_read !== 1'b0 || ap_idle !== 1'b1) begin
      bad++;
      $display("FAIL mid_rst aw=%b w=%b rd=%b idle=%b want=0 0 0 1",
               mif.awvalid, mif.wvalid, pix_read, ap_idle);
    end
    start_image(64'h5000, 2, 8);
    wait_done(3000, ok);
    total++;
    if (!ok || aw_err() != 0 || w_err() != 0) begin
      bad++; $display("FAIL mid_rerun done=%0d aw=%0d w=%0d want=1 0 0",
                      ok, aw_err(), w_err());
    end
    finish_run();
  endtask

  initial begin
    ap_rst = 1'b1; ap_start = 1'b0; ap_continue = 1'b0;
    cols = '0;
    test_reset();
    test_burst_split();
    test_outstanding();
    test_zero_dims();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pp_pipeline_accel_mem_writer.md
Name: pp_pipeline_accel_mem_writer

Overview:
- Dataflow sink stage of the pp_pipeline_accel region.
- Consumes the output-buffer base address (dout_c) and row count (rows_c) from the parameter FIFOs filled by the region's entry process.
- Consumes the processed pixel stream and writes the image to memory through an AXI4-style write master.
- Bursts are split at row ends, at MAX_BURST beats and at 4 KB boundaries.

Parameters:
- DATA_W, 64, pixel-word width in bits; power of two, at least 8.
- MAX_BURST, 16, maximum beats per burst; MAX_BURST*DATA_W/8 must not exceed 4096.
- MAX_OUT, 4, maximum AW bursts outstanding without a B response.

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  synchronous active-high reset
- ap_start  in  1  block start (ap_ctrl_hs)
- ap_done  out  1  run complete, held until ap_continue
- ap_continue  in  1  acknowledges ap_done
- ap_idle  out  1  idle and not started
- ap_ready  out  1  parameters consumed, ready for next start
- cols  in  16  pixel words per row, stable for the whole run
- dout_c_dout  in  64  base byte address (FWFT FIFO)
- dout_c_empty_n  in  1  address FIFO non-empty
- dout_c_read  out  1  address FIFO pop
- rows_c_dout  in  16  row count (FWFT FIFO)
- rows_c_empty_n  in  1  rows FIFO non-empty
- rows_c_read  out  1  rows FIFO pop
- pix_dout  in  DATA_W  pixel word (FWFT FIFO)
- pix_empty_n  in  1  pixel FIFO non-empty
- pix_read  out  1  pixel FIFO pop
- m_awvalid  out  1  write-address valid
- m_awready  in  1  write-address ready
- m_awaddr  out  64  burst start byte address
- m_awlen  out  8  beats minus one
- m_wvalid  out  1  write-data valid
- m_wready  in  1  write-data ready
- m_wdata  out  DATA_W  write data
- m_wlast  out  1  last beat of burst
- m_bvalid  in  1  write response valid
- m_bready  out  1  write response ready

Behaviour:
- Reset state:
  - State IDLE; outstanding counter 0.
  - ap_done, ap_ready, dout_c_read, rows_c_read, pix_read, m_awvalid, m_wvalid and m_wlast are all 0.
  - m_bready = !ap_rst.
- A reset in any state aborts the run:
  - IDLE on the next edge; no valid or read strobe is asserted in the cycle after reset.
  - Partially issued bursts are abandoned.
- States: IDLE, PARAM, AW, W, DRAIN, DONE.
- IDLE:
  - ap_idle = !ap_start.
  - ap_start=1 moves to PARAM.
- PARAM:
  - Waits until dout_c_empty_n and rows_c_empty_n are both 1.
  - In that cycle it pulses dout_c_read, rows_c_read and ap_ready together, and latches base, rows and cols.
  - Never pops one FIFO without the other.
  - If rows==0 or cols==0, goes to DONE with no memory traffic; otherwise goes to AW.
- Burst length:
  - beats = min(remaining in row, MAX_BURST, (4096 - addr[11:0]) / (DATA_W/8)).
  - m_awlen = beats-1.
  - Base address is DATA_W/8-aligned; behaviour is undefined otherwise.
- AW:
  - m_awvalid=1 only while outstanding < MAX_OUT.
  - m_awaddr and m_awlen are held stable until m_awready.
  - On handshake: outstanding +1, then go to W.
- W:
  - m_wvalid = pix_empty_n; m_wdata = pix_dout; pix_read = m_wvalid & m_wready (combinational).
  - m_wlast=1 on beat index beats-1.
  - Address advances by DATA_W/8 per beat.
  - At the end of a row, the column counter resets and the row counter increments.
  - After the last beat: go to AW if data remains, else DRAIN.
- B channel:
  - Each m_bvalid & m_bready decrements outstanding.
  - A simultaneous AW handshake and B response leaves outstanding unchanged.
  - Response codes are ignored.
- DRAIN: go to DONE when outstanding==0.
- DONE:
  - ap_done=1.
  - Stays in DONE until ap_continue=1, then returns to IDLE.
  - If ap_continue is already 1, ap_done lasts exactly one cycle.
- Total image size is rows*cols beats; counters are 16 bits, no wrap.

Decomposition:
- Shared package pp_pipeline_accel_pkg:
  - State enum.
  - AXI burst-length width constant (8).
  - Constant PAGE_BYTES=4096.
  - Function computing beats from remaining count, MAX_BURST and the address low bits.
- Sub-module pp_pipeline_accel_burst_calc (combinational burst-length/4 KB splitter) is natural. Everything else stays in the top FSM.

Test Plan:
- rows=2, cols=8, base 0x1000, all ready=1 -> two AW (0x1000 len 7; 0x1040 len 7), 16 W beats with wlast on beats 8 and 16, ap_done after 2 B responses.
- rows=1, cols=40, MAX_BURST=16 -> AW len 15, 15, 7 at 0x0, 0x80, 0x100.
- base 0x0FF0, rows=1, cols=8 -> AW 0x0FF0 len 1, then AW 0x1000 len 5 (4 KB split).
- bvalid held 0, rows=6, cols=4 -> exactly 4 AW issued, m_awvalid stays 0 until first B; simultaneous AW and B keeps count at 4.
- rows=0 -> one cycle with both FIFO reads and ap_ready, no AW; ap_done held until ap_continue pulse, then IDLE.
- ap_rst asserted mid-W -> next cycle m_awvalid=m_wvalid=pix_read=0, state IDLE, new run completes correctly.
